otter_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined OTTER core. It replaces the single IF/ID register with a PC generator plus a DEPTH-entry prefetch FIFO, and drives the synchronous instruction port of memory. Decode consumes instructions through a valid/ready handshake, so decode stalls no longer gate the PC. An execute-stage redirect (branch, jump, trap, mret) flushes all queued and in-flight fetches.

---
 rtl/otter_fetch_queue.sv | 155 +++++++++++++++
 tb/tb_otter_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_queue.sv
// Instruction-fetch front end: PC generator, one-deep in-flight tracker and a
// DEPTH-entry prefetch FIFO feeding decode through a valid/ready handshake.
module otter_fetch_queue #(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    DEPTH     = 4,
  parameter int unsigned    ADDR_W    = 14,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       imem_rden_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic [31:0]                imem_dout_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [31:0]                id_instr_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [XLEN-1:0]            id_npc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
  logic             inflight_q,    inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0] count_q,       count_d;

  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and credit logic
  // ---------------------------------------------------------------------------
  logic             head_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occupancy;
  logic [XLEN-1:0]  redirect_target;
  logic             unused_redirect_lsbs;

  assign head_valid = (count_q != '0);
  assign pop        = head_valid & id_ready_i & ~redirect_i;
  assign push       = inflight_q & ~redirect_i;

  // Entries already committed (queued plus the read in flight), less the one
  // leaving this cycle; a new read is only issued when it is guaranteed a slot.
  assign occupancy  = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue      = rst_ni & ~redirect_i & (occupancy < OCC_W'(DEPTH));

  assign redirect_target      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_VEC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage, one write-enabled slot per entry
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic slot_we;
    assign slot_we = push & (wr_ptr_q == PTR_W'(gi));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        instr_q[gi] <= '0;
        pc_q[gi]    <= '0;
      end else if (slot_we) begin
        instr_q[gi] <= imem_dout_i;
        pc_q[gi]    <= inflight_pc_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The address is forced to zero in reset rather than showing RESET_VEC.
  assign imem_rden_o = issue;
  assign imem_addr_o = rst_ni ? fetch_pc_q[ADDR_W+1:2] : '0;

  assign id_valid_o  = head_valid;
  assign id_instr_o  = head_valid ? instr_q[rd_ptr_q] : '0;
  assign id_pc_o     = head_valid ? pc_q[rd_ptr_q] : '0;
  assign id_npc_o    = head_valid ? (pc_q[rd_ptr_q] + XLEN'(4)) : '0;
  assign count_o     = count_q;

  // The credit check makes this unreachable; firing means the accounting broke.
  push_when_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue: free run, backpressure, redirects,
// asynchronous reset mid-stream and PC wrap (second instance).
module tb_otter_fetch_queue;

  localparam int ADDR_W = 14;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_VEC = 0x100
  logic        rst_n, redirect, id_ready;
  logic [31:0] redirect_pc;
  logic        imem_rden, id_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_dout, id_instr, id_pc, id_npc;
  logic [2:0]  count;

  // Instance B: RESET_VEC = 0xFFFFFFF8
  logic        rst2_n, redirect2, id_ready2;
  logic [31:0] redirect_pc2;
  logic        imem_rden2, id_valid2;
  logic [ADDR_W-1:0] imem_addr2;
  logic [31:0] imem_dout2, id_instr2, id_pc2, id_npc2;
  logic [2:0]  count2;

  int n_tests = 0;
  int n_fail  = 0;

  otter_fetch_queue #(.XLEN(32), .DEPTH(4), .ADDR_W(ADDR_W), .RESET_VEC(32'h0000_0100)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_rden_o(imem_rden), .imem_addr_o(imem_addr), .imem_dout_i(imem_dout),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_instr_o(id_instr),
    .id_pc_o(id_pc), .id_npc_o(id_npc), .count_o(count)
  );

  otter_fetch_queue #(.XLEN(32), .DEPTH(4), .ADDR_W(ADDR_W), .RESET_VEC(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_ni(rst2_n), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
    .imem_rden_o(imem_rden2), .imem_addr_o(imem_addr2), .imem_dout_i(imem_dout2),
    .id_valid_o(id_valid2), .id_ready_i(id_ready2), .id_instr_o(id_instr2),
    .id_pc_o(id_pc2), .id_npc_o(id_npc2), .count_o(count2)
  );

  // Synchronous instruction memory: word = 0xA0000000 | word address.
  // Unrequested cycles return a poison value that must never reach decode.
  always @(posedge clk) begin
    imem_dout  <= imem_rden  ? (32'hA000_0000 | {18'b0, imem_addr})  : 32'hDEAD_BEEF;
    imem_dout2 <= imem_rden2 ? (32'hA000_0000 | {18'b0, imem_addr2}) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    rst2_n = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0; id_ready2 = 1'b1;

    // ---------------- Backpressure fill from reset ----------------
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("bp_c0_count", 32'(count), 32'd0);
    chk("bp_c0_valid", 32'(id_valid), 32'd0);
    chk("bp_c0_rden", 32'(imem_rden), 32'd1);
    chk("bp_c0_addr", 32'(imem_addr), 32'h40);
    tick(); #1;
    chk("bp_c1_count", 32'(count), 32'd0);
    chk("bp_c1_addr", 32'(imem_addr), 32'h41);
    tick(); #1;
    chk("bp_c2_count", 32'(count), 32'd1);
    chk("bp_c2_valid", 32'(id_valid), 32'd1);
    chk("bp_c2_pc", id_pc, 32'h100);
    chk("bp_c2_npc", id_npc, 32'h104);
    chk("bp_c2_instr", id_instr, 32'hA000_0040);
    tick(); #1;
    chk("bp_c3_count", 32'(count), 32'd2);
    tick(); #1;
    chk("bp_c4_count", 32'(count), 32'd3);
    chk("bp_c4_rden", 32'(imem_rden), 32'd0);
    tick(); #1;
    chk("bp_c5_count", 32'(count), 32'd4);
    chk("bp_c5_rden", 32'(imem_rden), 32'd0);
    chk("bp_c5_pc", id_pc, 32'h100);
    tick(); #1;
    chk("bp_c6_count", 32'(count), 32'd4);
    chk("bp_c6_pc", id_pc, 32'h100);
    chk("bp_c6_instr", id_instr, 32'hA000_0040);
    tick(); id_ready = 1'b1; #1;
    chk("bp_c7_rden", 32'(imem_rden), 32'd1);
    chk("bp_c7_addr", 32'(imem_addr), 32'h44);
    chk("bp_c7_pc", id_pc, 32'h100);
    tick(); #1;
    chk("bp_c8_pc", id_pc, 32'h104);
    chk("bp_c8_count", 32'(count), 32'd3);
    tick(); #1;
    chk("bp_c9_pc", id_pc, 32'h108);
    tick(); #1;
    chk("bp_c10_pc", id_pc, 32'h10C);
    tick(); #1;
    chk("bp_c11_pc", id_pc, 32'h110);
    chk("bp_c11_instr", id_instr, 32'hA000_0044);
    chk("bp_c11_count", 32'(count), 32'd3);

    // ---------------- Asynchronous reset mid-stream ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rden", 32'(imem_rden), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_npc", id_npc, 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // ---------------- Free run after release ----------------
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("fr_c0_rden", 32'(imem_rden), 32'd1);
    chk("fr_c0_addr", 32'(imem_addr), 32'h40);
    tick(); #1;
    chk("fr_c1_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    chk("fr_c2_valid", 32'(id_valid), 32'd1);
    chk("fr_c2_pc", id_pc, 32'h100);
    chk("fr_c2_npc", id_npc, 32'h104);
    tick(); #1;
    chk("fr_c3_pc", id_pc, 32'h104);
    chk("fr_c3_count", 32'(count), 32'd1);
    tick(); #1;
    chk("fr_c4_pc", id_pc, 32'h108);
    chk("fr_c4_instr", id_instr, 32'hA000_0042);
    chk("fr_c4_count", 32'(count), 32'd1);

    // ---------------- Redirect with a full queue ----------------
    tick(); id_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_rden", 32'(imem_rden), 32'd0);
    chk("full_pc", id_pc, 32'h10C);
    tick(); redirect = 1'b1; redirect_pc = 32'h2003; id_ready = 1'b1; #1;
    chk("rdf_r0_rden", 32'(imem_rden), 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("rdf_r1_count", 32'(count), 32'd0);
    chk("rdf_r1_valid", 32'(id_valid), 32'd0);
    chk("rdf_r1_pc", id_pc, 32'd0);
    chk("rdf_r1_rden", 32'(imem_rden), 32'd1);
    chk("rdf_r1_addr", 32'(imem_addr), 32'h800);
    tick(); #1;
    chk("rdf_r2_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    chk("rdf_r3_valid", 32'(id_valid), 32'd1);
    chk("rdf_r3_pc", id_pc, 32'h2000);
    chk("rdf_r3_instr", id_instr, 32'hA000_0800);
    chk("rdf_r3_npc", id_npc, 32'h2004);
    tick(); #1;
    chk("rdf_r4_pc", id_pc, 32'h2004);
    chk("rdf_r4_count", 32'(count), 32'd1);

    // ---------------- Redirect while a fetch is in flight ----------------
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #1;
    tick(); redirect = 1'b0; #1;
    chk("rdi_issue_rden", 32'(imem_rden), 32'd1);
    chk("rdi_issue_addr", 32'(imem_addr), 32'h10);
    tick(); redirect = 1'b1; redirect_pc = 32'h80; #1;
    chk("rdi_r0_rden", 32'(imem_rden), 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("rdi_r1_valid", 32'(id_valid), 32'd0);
    chk("rdi_r1_count", 32'(count), 32'd0);
    chk("rdi_r1_addr", 32'(imem_addr), 32'h20);
    tick(); #1;
    chk("rdi_r2_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    chk("rdi_r3_valid", 32'(id_valid), 32'd1);
    chk("rdi_r3_pc", id_pc, 32'h80);
    chk("rdi_r3_instr", id_instr, 32'hA000_0020);

    // ---------------- PC wrap on the second instance ----------------
    tick(); rst2_n = 1'b1; #1;
    chk("wr_c0_rden", 32'(imem_rden2), 32'd1);
    chk("wr_c0_addr", 32'(imem_addr2), 32'h3FFE);
    tick(); #1;
    chk("wr_c1_addr", 32'(imem_addr2), 32'h3FFF);
    tick(); #1;
    chk("wr_c2_pc", id_pc2, 32'hFFFF_FFF8);
    chk("wr_c2_npc", id_npc2, 32'hFFFF_FFFC);
    chk("wr_c2_instr", id_instr2, 32'hA000_3FFE);
    chk("wr_c2_addr", 32'(imem_addr2), 32'h0000);
    tick(); #1;
    chk("wr_c3_pc", id_pc2, 32'hFFFF_FFFC);
    chk("wr_c3_npc", id_npc2, 32'h0000_0000);
    tick(); #1;
    chk("wr_c4_pc", id_pc2, 32'h0000_0000);
    chk("wr_c4_npc", id_npc2, 32'h0000_0004);
    chk("wr_c4_instr", id_instr2, 32'hA000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
